// File: rtl/dircc_rts_pkg.sv
// Shared types and helpers for the DiRCC ready-to-send handler.
package dircc_rts_pkg;

    localparam int STATE_WORD_W = 32;

    // System-state bit that marks a device as running; RTS is only honoured then.
    localparam logic [STATE_WORD_W-1:0] DIRCC_STATE_RUNNING = 32'h0000_0004;

    typedef struct packed {
        logic [STATE_WORD_W-1:0] dircc_state;
        logic [STATE_WORD_W-1:0] user_state;
    } device_state_t;

    typedef enum logic {
        IDLE,
        BUSY
    } rts_fsm_t;

    typedef enum logic {
        ARB_FIXED,
        ARB_ROUND_ROBIN
    } rts_arb_mode_t;

    // Per-port RTS mask from a device state: low n user bits, zero unless running.
    function automatic logic [STATE_WORD_W-1:0] rts_mask_from_state(input device_state_t s,
                                                                    input int n);
        logic [STATE_WORD_W-1:0] keep;
        keep = (n >= STATE_WORD_W) ? '1 : ((32'h1 << n) - 32'h1);
        return ((s.dircc_state & DIRCC_STATE_RUNNING) != '0) ? (s.user_state & keep) : '0;
    endfunction

endpackage

// File: rtl/dircc_rr_select.sv
// Combinational port picker: lowest set request, or first set at/after ptr with wrap.
module dircc_rr_select
    import dircc_rts_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    input  rts_arb_mode_t        mode,
    output logic                 found,
    output logic [PW-1:0]        index
);

    // Scan NUM_PORTS candidates starting at 0 (fixed) or ptr (round-robin); first hit wins.
    always_comb begin
        int c;
        found = 1'b0;
        index = '0;
        c     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            c = (mode == ARB_ROUND_ROBIN) ? int'(ptr) + k : k;
            if (c >= NUM_PORTS) c = c - NUM_PORTS;
            if (!found && req[c]) begin
                found = 1'b1;
                index = PW'(c);
            end
        end
    end

endmodule

// File: rtl/dircc_rts_multiport_handler.sv
// Latches a device's per-port RTS mask on a state read and hands out one grant per port.
module dircc_rts_multiport_handler
    import dircc_rts_pkg::*;
#(
    parameter int    ADDRESS_MEM_WIDTH = 32,
    parameter int    NUM_PORTS         = 4,
    parameter int    RTS_WIDTH         = 32,
    parameter string ARB_MODE          = "round_robin",
    parameter string NODE_TYPE         = "default"
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  state_valid,
    output logic                                  state_ready,
    input  logic [ADDRESS_MEM_WIDTH-1:0]          address,
    input  device_state_t                         read_state,
    output logic [RTS_WIDTH-1:0]                  rts_ready,
    output logic                                  grant_valid,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_port,
    output logic [ADDRESS_MEM_WIDTH-1:0]          grant_address,
    input  logic                                  grant_ready
);

    localparam int            PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam rts_arb_mode_t MODE = (ARB_MODE == "fixed") ? ARB_FIXED : ARB_ROUND_ROBIN;

    // Node type only selects application tables elsewhere; nothing here depends on it.
    localparam bit unused_node_is_default = (NODE_TYPE == "default");

    rts_fsm_t                     state_q, state_d;
    logic [NUM_PORTS-1:0]         pend_q, pend_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic [ADDRESS_MEM_WIDTH-1:0] addr_d;
    logic [STATE_WORD_W-1:0]      cap_mask;
    logic                         sel_found;
    logic [PW-1:0]                sel_index;
    logic                         unused_mask_hi;

    assign cap_mask       = rts_mask_from_state(read_state, NUM_PORTS);
    assign unused_mask_hi = ^cap_mask[STATE_WORD_W-1:NUM_PORTS];

    // pending is itself a register, so this is the registered image the sender polls.
    assign rts_ready = RTS_WIDTH'(pend_q);

    // Next-state: capture in IDLE, retire the presented grant in BUSY.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        addr_d  = grant_address;
        case (state_q)
            IDLE: begin
                if (state_valid) begin
                    pend_d = cap_mask[NUM_PORTS-1:0];
                    addr_d = address;
                    if (pend_d != '0) state_d = BUSY;
                end
            end
            BUSY: begin
                // New reads are dropped here; the sender re-polls after we go idle.
                if (grant_valid && grant_ready) begin
                    pend_d = pend_q & ~(NUM_PORTS'(1) << grant_port);
                    if (MODE == ARB_ROUND_ROBIN)
                        ptr_d = (grant_port == PW'(NUM_PORTS - 1)) ? '0 : grant_port + 1'b1;
                    if (pend_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Selecting on the next pending/pointer lets grants run back-to-back.
    dircc_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_select (
        .req   (pend_d),
        .ptr   (ptr_d),
        .mode  (MODE),
        .found (sel_found),
        .index (sel_index)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Pending set, pointer and all registered outputs; grant_port holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q        <= '0;
            ptr_q         <= '0;
            grant_valid   <= 1'b0;
            grant_port    <= '0;
            grant_address <= '0;
            state_ready   <= 1'b1;
        end else begin
            pend_q        <= pend_d;
            ptr_q         <= ptr_d;
            grant_valid   <= sel_found;
            grant_address <= addr_d;
            state_ready   <= (state_d == IDLE);
            if (sel_found) grant_port <= sel_index;
        end
    end

endmodule

// File: tb/tb_dircc_rts_multiport_handler.sv
// Bench: fixed 4-port, round-robin 4-port and 1-port handlers share one state-read stream.
module tb_dircc_rts_multiport_handler;
    import dircc_rts_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          state_valid = 1'b0;
    logic [31:0]   address = '0;
    device_state_t read_state = '0;
    logic          grant_ready [3];
    logic          sr [3];
    logic          gv [3];
    logic [31:0]   rts [3];
    logic [31:0]   gaddr [3];
    logic [31:0]   gpv [3];
    logic [1:0]    gp_f, gp_r;
    logic          gp_1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: outstanding port set, rotation pointer, latched address.
    logic [31:0] m_pend [3];
    int          m_ptr [3];
    logic [31:0] m_addr [3];

    localparam logic [31:0] RUN = DIRCC_STATE_RUNNING;

    always #5 clk = ~clk;

    assign gpv[0] = 32'(gp_f);
    assign gpv[1] = 32'(gp_r);
    assign gpv[2] = 32'(gp_1);

    dircc_rts_multiport_handler #(.ADDRESS_MEM_WIDTH(32), .NUM_PORTS(4), .RTS_WIDTH(32),
        .ARB_MODE("fixed"), .NODE_TYPE("default")) u_fixed (
        .clk(clk), .reset_n(reset_n), .state_valid(state_valid), .state_ready(sr[0]),
        .address(address), .read_state(read_state), .rts_ready(rts[0]),
        .grant_valid(gv[0]), .grant_port(gp_f), .grant_address(gaddr[0]),
        .grant_ready(grant_ready[0]));

    dircc_rts_multiport_handler #(.ADDRESS_MEM_WIDTH(32), .NUM_PORTS(4), .RTS_WIDTH(32),
        .ARB_MODE("round_robin"), .NODE_TYPE("default")) u_rr (
        .clk(clk), .reset_n(reset_n), .state_valid(state_valid), .state_ready(sr[1]),
        .address(address), .read_state(read_state), .rts_ready(rts[1]),
        .grant_valid(gv[1]), .grant_port(gp_r), .grant_address(gaddr[1]),
        .grant_ready(grant_ready[1]));

    dircc_rts_multiport_handler #(.ADDRESS_MEM_WIDTH(32), .NUM_PORTS(1), .RTS_WIDTH(32),
        .ARB_MODE("round_robin"), .NODE_TYPE("default")) u_one (
        .clk(clk), .reset_n(reset_n), .state_valid(state_valid), .state_ready(sr[2]),
        .address(address), .read_state(read_state), .rts_ready(rts[2]),
        .grant_valid(gv[2]), .grant_port(gp_1), .grant_address(gaddr[2]),
        .grant_ready(grant_ready[2]));

    function automatic int nports(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Port the sender should see: lowest set, or first set at/after the pointer.
    function automatic int next_grant(input int d);
        int n, i;
        n = nports(d);
        for (int k = 0; k < n; k++) begin
            i = (d != 0) ? (m_ptr[d] + k) % n : k;
            if (m_pend[d][i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk("rts_ready", d, rts[d], m_pend[d]);
            chk("grant_valid", d, 32'(gv[d]), 32'(m_pend[d] != 0));
            chk("state_ready", d, 32'(sr[d]), 32'(m_pend[d] == 0));
            chk("grant_address", d, gaddr[d], m_addr[d]);
            if (m_pend[d] != 0) chk("grant_port", d, gpv[d], 32'(next_grant(d)));
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_state_ready"}, d, 32'(sr[d]), 32'd1);
            chk({tag, "_grant_valid"}, d, 32'(gv[d]), 32'd0);
            chk({tag, "_grant_port"}, d, gpv[d], 32'd0);
            chk({tag, "_grant_address"}, d, gaddr[d], 32'd0);
            chk({tag, "_rts_ready"}, d, rts[d], 32'd0);
        end
    endtask

    // One cycle, entered at a falling edge: check outputs, drive inputs, advance model.
    task automatic step(input bit sv, input logic [31:0] ds, input logic [31:0] us,
                        input logic [31:0] ad, input logic [2:0] gr);
        int g, n;
        check_all();
        state_valid            = sv;
        read_state.dircc_state = ds;
        read_state.user_state  = us;
        address                = ad;
        for (int d = 0; d < 3; d++) begin
            grant_ready[d] = gr[d];
            n = nports(d);
            if (m_pend[d] == 0) begin
                if (sv) begin
                    m_pend[d] = ((ds & RUN) != 0) ? (us & ((32'h1 << n) - 1)) : 32'h0;
                    m_addr[d] = ad;
                end
            end else if (gr[d]) begin
                g = next_grant(d);
                m_pend[d] = m_pend[d] & ~(32'h1 << g);
                if (d != 0) m_ptr[d] = (g + 1) % n;
            end
        end
        @(negedge clk);
    endtask

    // Pull reset between edges, check outputs clear without a clock, release later.
    task automatic async_reset();
        state_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        for (int d = 0; d < 3; d++) begin
            m_pend[d] = 0;
            m_ptr[d]  = 0;
            m_addr[d] = 0;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            grant_ready[d] = 1'b0;
            m_pend[d] = 0;
            m_ptr[d]  = 0;
            m_addr[d] = 0;
        end
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Running, mask 1011, always ready: 0,1,3 back-to-back.
        step(1, RUN, 32'h0000_000B, 32'hA000_0010, 3'b111);
        repeat (4) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Leave the rotation pointer at 2, then mask 0011 must wrap to 0 then 1.
        step(1, RUN, 32'h0000_0002, 32'hA000_0020, 3'b111);
        repeat (2) step(0, RUN, 32'h0, 32'h0, 3'b111);
        step(1, RUN, 32'h0000_0003, 32'hA000_0030, 3'b111);
        repeat (3) step(0, RUN, 32'h0, 32'h0, 3'b111);
        // Pointer should now sit at 2: mask 0101 grants 2 before 0.
        step(1, RUN, 32'h0000_0005, 32'hA000_0040, 3'b111);
        repeat (3) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Full mask but not running: nothing pending.
        step(1, 32'h0000_0003, 32'h0000_000F, 32'hA000_0050, 3'b111);
        repeat (2) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Stalled sender with extra state reads that must be ignored.
        step(1, RUN, 32'h0000_0004, 32'hA000_0060, 3'b000);
        for (int i = 0; i < 5; i++)
            step(i[0] == 1'b0, RUN, 32'h0000_000F, 32'hBEEF_0000 + 32'(i), 3'b000);
        step(0, RUN, 32'h0, 32'h0, 3'b111);
        repeat (2) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Reset while two ports are pending, then a fresh capture starts at port 0.
        step(1, RUN, 32'h0000_0006, 32'hA000_0070, 3'b000);
        step(0, RUN, 32'h0, 32'h0, 3'b000);
        async_reset();
        step(1, RUN, 32'h0000_000F, 32'hA000_0080, 3'b111);
        repeat (5) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Upper user bits set: single-port handler sees only bit 0.
        step(1, RUN | 32'h0000_0100, 32'hFFFF_FFFF, 32'hA000_0090, 3'b111);
        repeat (5) step(0, RUN, 32'h0, 32'h0, 3'b111);
        step(1, RUN, 32'hFFFF_FFFE, 32'hA000_00A0, 3'b111);
        repeat (5) step(0, RUN, 32'h0, 32'h0, 3'b111);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ds;
            ds = ($urandom_range(0, 3) == 0) ? ($urandom & ~RUN) : ($urandom | RUN);
            if ($urandom_range(0, 60) == 0) async_reset();
            step($urandom_range(0, 1) == 1, ds, $urandom, $urandom,
                 3'($urandom_range(0, 7)));
        end
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
